seg_7_reader: RTL and testbench
===============================

SEG_7_READER -- requirements
Module: seg_7_reader

Interface
REQ-001 Parameter STABLE_CNT, default 4, range 2..15: consecutive identical cycles required before a digit is accepted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg  input  7  segment pattern, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-005 an  input  4  digit enable, active-high, one-hot; an[i] selects digit slot i.
REQ-006 out_bcd  output  16  captured frame; bcd[4i+3:4i] = digit slot i.
REQ-007 out_err  output  4  per-slot flag: pattern not in decode table and not blank.
REQ-008 out_valid  output  1  frame available.
REQ-009 out_ready  input  1  consumer accepts frame.
REQ-010 overrun  output  1  sticky: a completed frame was dropped.

Function
REQ-011 Decode table (seg -> digit): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-012 Pattern 0000000 (blank) SHALL decode to 4'hF with err=0.
REQ-013 Any other pattern SHALL decode to 4'hF with err=1.
REQ-014 Stability counter: if (an,seg) equals previous cycle's sampled value and an is one-hot, increment, saturating at STABLE_CNT; otherwise load 1.
REQ-015 an zero or multi-hot SHALL load the counter with 0 and capture nothing.
REQ-016 Capture SHALL occur exactly once per stable run, on the cycle the counter transitions to STABLE_CNT: decoded digit/err written to slot i, mask bit i set.
REQ-017 Recapture of a slot already in the mask SHALL overwrite that slot's digit and err.
REQ-018 States: COLLECT (mask filling) and HOLD (out_valid=1).
REQ-019 COLLECT->HOLD: cycle after the capture that makes mask=4'b1111; out_bcd/out_err load from slots and mask clears on the same edge that sets out_valid.
REQ-020 HOLD: out_bcd, out_err stable; capture into slots continues while in HOLD.
REQ-021 HOLD->COLLECT on the edge where out_valid && out_ready.
REQ-022 Frame completes in HOLD with out_ready=0 that cycle: new frame dropped, mask cleared, overrun set.
REQ-023 Simultaneous frame completion and out_ready=1 in HOLD: new frame loaded, out_valid stays 1, no overrun.
REQ-024 overrun SHALL clear only on reset.
REQ-025 Latency: seg/an stable from cycle t -> capture at edge t+STABLE_CNT-1; out_valid high one cycle after final capture.

Reset
REQ-026 On rst: out_bcd=16'hFFFF, out_err=0, out_valid=0, overrun=0, mask=0, counter=0, state COLLECT, slots=4'hF.
REQ-027 rst mid-run or in HOLD SHALL discard partial and pending frames; first capture needs a fresh full stable run.

Structure
REQ-028 Shared package seg7_pkg: segment pattern constants for 0-9 and blank, STABLE_CNT default, state enum.
REQ-029 Sub-module seg_7_decoder: combinational seg[6:0] -> {err, digit[3:0]} per REQ-011..013.

Verification
REQ-030 Drive an=0001,0010,0100,1000 with 1111001,0110011,1011011,1011111, 4 cycles each, out_ready=1 -> out_bcd=16'h6543, out_err=0, out_valid one cycle.
REQ-031 Hold an=0001, seg=1111110 for 20 cycles -> exactly one capture of slot 0.
REQ-032 Slot 2 seg=1001001 stable 4 cycles, others valid -> out_err=4'b0100, slot 2=F; blank in slot 3 -> F, err bit 3=0.
REQ-033 Stable runs of 3 cycles (STABLE_CNT=4), or an=0011 -> no capture, out_valid stays 0.
REQ-034 Two complete frames with out_ready=0 -> first frame held, overrun=1; out_ready=1 -> COLLECT next edge.
REQ-035 rst asserted after 3 of 4 slots captured -> outputs at reset values; next frame needs all 4 slots.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment pattern constants, stability default and reader state encoding
package seg7_pkg;
    localparam int STABLE_CNT_DEF = 4;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    typedef enum logic {ST_COLLECT = 1'b0, ST_HOLD = 1'b1} state_t;
endpackage

// File: rtl/seg_7_reader_if.sv
// seg_7_reader_if: display bus (seg, an, out_ready in; out_bcd, out_err, out_valid, overrun out)
interface seg_7_reader_if;
    logic [6:0] seg;
    logic [3:0] an;
    logic out_ready;
    logic [15:0] out_bcd;
    logic [3:0] out_err;
    logic out_valid;
    logic overrun;
    modport master(output seg, an, out_ready, input out_bcd, out_err, out_valid, overrun);
    modport slave(input seg, an, out_ready, output out_bcd, out_err, out_valid, overrun);
endinterface

// File: rtl/seg_7_decoder.sv
// seg_7_decoder: seg[6:0] -> dec = {err, digit[3:0]}; blank gives F/no err, unknown gives F/err
module seg_7_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [4:0] dec
);
    always_comb begin
        dec = 5'h1F;
        case (seg)
            SEG_0: dec = 5'h00;
            SEG_1: dec = 5'h01;
            SEG_2: dec = 5'h02;
            SEG_3: dec = 5'h03;
            SEG_4: dec = 5'h04;
            SEG_5: dec = 5'h05;
            SEG_6: dec = 5'h06;
            SEG_7: dec = 5'h07;
            SEG_8: dec = 5'h08;
            SEG_9: dec = 5'h09;
            SEG_BLANK: dec = 5'h0F;
            default: dec = 5'h1F;
        endcase
    end
endmodule

// File: rtl/seg_7_reader.sv
// seg_7_reader: captures stable multiplexed 7-seg digits into a 4-slot frame; ports clk, rst, bus (slave)
module seg_7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input logic clk,
    input logic rst,
    seg_7_reader_if.slave bus
);
    localparam logic [0:0] COLLECT = 1'(ST_COLLECT);
    localparam logic [0:0] HOLD = 1'(ST_HOLD);
    localparam logic [3:0] SAT = 4'(STABLE_CNT);
    logic [3:0] prev_an, cnt, cnt_nxt, mask, mask_nxt, err;
    logic [6:0] prev_seg;
    logic [3:0] digit [4];
    logic [4:0] dec;
    logic [1:0] idx;
    logic one_hot, cap, full;
    logic [0:0] state;
    seg_7_decoder u_dec (.seg(bus.seg), .dec(dec));
    always_comb begin
        idx = 2'd0;
        for (int k = 0; k < 4; k++) if (bus.an[k]) idx = 2'(k);
        one_hot = bus.an != 4'd0 && (bus.an & (bus.an - 4'd1)) == 4'd0;
        cnt_nxt = !one_hot ? 4'd0 : ({bus.an, bus.seg} != {prev_an, prev_seg}) ? 4'd1 : (cnt == SAT) ? cnt : cnt + 4'd1;
        cap = cnt_nxt == SAT && cnt != SAT;
        full = mask == 4'hF;
        mask_nxt = (full ? 4'd0 : mask) | ({3'd0, cap} << idx);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_an <= 4'd0;
            prev_seg <= 7'd0;
            cnt <= 4'd0;
            mask <= 4'd0;
            err <= 4'd0;
            state <= COLLECT;
            bus.out_bcd <= 16'hFFFF;
            bus.out_err <= 4'd0;
            bus.overrun <= 1'b0;
            for (int k = 0; k < 4; k++) digit[k] <= 4'hF;
        end else begin
            prev_an <= bus.an;
            prev_seg <= bus.seg;
            cnt <= cnt_nxt;
            mask <= mask_nxt;
            if (cap) begin
                digit[idx] <= dec[3:0];
                err[idx] <= dec[4];
            end
            if (full && (state == COLLECT || bus.out_ready)) begin
                bus.out_bcd <= {digit[3], digit[2], digit[1], digit[0]};
                bus.out_err <= err;
            end
            if (full && state == HOLD && !bus.out_ready) bus.overrun <= 1'b1;
            if (full) state <= HOLD;
            else if (bus.out_ready) state <= COLLECT;
        end
    end
    assign bus.out_valid = state == HOLD;
endmodule

// File: tb/tb_seg_7_reader.sv
// tb_seg_7_reader: table-driven frames plus corner sequences, scoreboard checked on each handshake
module tb_seg_7_reader;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    logic [19:0] sb [$];
    logic [19:0] exp_f;
    typedef struct {
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
        logic [15:0] bcd;
        logic [3:0] err;
    } vec_t;
    vec_t tbl [4];
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SB = 7'b0000000, SX = 7'b1001001;
    seg_7_reader_if bus ();
    seg_7_reader #(.STABLE_CNT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an = a;
        bus.seg = s;
        step(n);
    endtask
    task automatic chk_reset(input string nm);
        chk({nm, "_bcd"}, 32'(bus.out_bcd), 32'hFFFF);
        chk({nm, "_err"}, 32'(bus.out_err), 32'h0);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'h0);
        chk({nm, "_overrun"}, 32'(bus.overrun), 32'h0);
    endtask
    task automatic pulse(input string nm);
        step(1);
        chk({nm, "_valid_rise"}, 32'(bus.out_valid), 32'h1);
        step(1);
        chk({nm, "_valid_fall"}, 32'(bus.out_valid), 32'h0);
    endtask
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got bcd=%0h err=%0h want none", bus.out_bcd, bus.out_err);
            end else begin
                exp_f = sb.pop_front();
                chk("frame_bcd", 32'(bus.out_bcd), 32'(exp_f[19:4]));
                chk("frame_err", 32'(bus.out_err), 32'(exp_f[3:0]));
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1;
        bus.an = 4'd0;
        bus.seg = 7'd0;
        bus.out_ready = 1'b1;
        tbl[0] = '{an: {4'h8, 4'h4, 4'h2, 4'h1}, seg: {S6, S5, S4, S3}, bcd: 16'h6543, err: 4'b0000};
        tbl[1] = '{an: {4'h8, 4'h4, 4'h2, 4'h1}, seg: {SB, SX, S1, S0}, bcd: 16'hFF10, err: 4'b0100};
        tbl[2] = '{an: {4'h8, 4'h4, 4'h2, 4'h1}, seg: {S2, S9, S8, S7}, bcd: 16'h2987, err: 4'b0000};
        tbl[3] = '{an: {4'h1, 4'h2, 4'h4, 4'h8}, seg: {S3, S2, S1, S0}, bcd: 16'h0123, err: 4'b0000};
        step(2);
        chk_reset("reset");
        rst = 1'b0;
        for (int v = 0; v < 4; v++) begin
            sb.push_back({tbl[v].bcd, tbl[v].err});
            for (int s = 0; s < 4; s++) hold(tbl[v].an[s], tbl[v].seg[s], 4);
            chk("tbl_valid_pre", 32'(bus.out_valid), 32'h0);
            pulse("tbl");
        end
        chk("overrun_idle", 32'(bus.overrun), 32'h0);
        sb.push_back({16'h3210, 4'h0});
        hold(4'h1, S0, 20);
        chk("long_hold_valid", 32'(bus.out_valid), 32'h0);
        hold(4'h2, S1, 4);
        hold(4'h4, S2, 4);
        hold(4'h8, S3, 4);
        pulse("long");
        hold(4'h8, S9, 3);
        hold(4'h1, S5, 3);
        hold(4'b0011, S5, 6);
        hold(4'h0, S5, 3);
        chk("short_valid", 32'(bus.out_valid), 32'h0);
        hold(4'h1, S1, 4);
        hold(4'h2, S2, 4);
        hold(4'h4, S3, 4);
        step(3);
        chk("no_capture_short", 32'(bus.out_valid), 32'h0);
        sb.push_back({16'h4321, 4'h0});
        hold(4'h8, S4, 4);
        pulse("short");
        bus.out_ready = 1'b0;
        sb.push_back({16'h6543, 4'h0});
        hold(4'h1, S3, 4);
        hold(4'h2, S4, 4);
        hold(4'h4, S5, 4);
        hold(4'h8, S6, 4);
        step(1);
        chk("hold_valid", 32'(bus.out_valid), 32'h1);
        hold(4'h1, S7, 4);
        hold(4'h2, S8, 4);
        hold(4'h4, S9, 4);
        hold(4'h8, S2, 4);
        step(2);
        chk("held_valid", 32'(bus.out_valid), 32'h1);
        chk("held_bcd", 32'(bus.out_bcd), 32'h6543);
        chk("overrun_set", 32'(bus.overrun), 32'h1);
        bus.out_ready = 1'b1;
        step(1);
        chk("release_valid", 32'(bus.out_valid), 32'h0);
        chk("overrun_sticky", 32'(bus.overrun), 32'h1);
        hold(4'h1, S0, 4);
        hold(4'h2, S1, 4);
        hold(4'h4, S2, 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_reset("midrst");
        hold(4'h8, S3, 4);
        step(3);
        chk("rst_discard", 32'(bus.out_valid), 32'h0);
        sb.push_back({16'h3765, 4'h0});
        hold(4'h1, S5, 4);
        hold(4'h2, S6, 4);
        hold(4'h4, S7, 4);
        pulse("after_rst");
        step(2);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
